// File: rtl/bandai_mapper_gen2.sv
// Cartridge mapper: address-key unlock FSM, serial boot stream, bank registers, chip-select decode.
// Define BANDAI_READBACK_EN to make the bank registers readable on DQ_O/DQ_OE.
module bandai_mapper_gen2 #(
    parameter int unsigned           RADDR_W    = 7,
    parameter int unsigned           BANK_W     = 8,
    parameter int unsigned           STREAM_LEN = 18,
    parameter logic [STREAM_LEN-1:0] STREAM_PAT = 18'h05140,
    parameter logic [7:0]            KEY0       = 8'h5A,
    parameter logic [7:0]            KEY1       = 8'hA5
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               CEn,
    input  logic               SSn,
    input  logic               WEn,
    input  logic               OEn,
    input  logic [7:0]         ADDR,
    input  logic [7:0]         DQ_I,
    output logic [7:0]         DQ_O,
    output logic               DQ_OE,
    output logic               SO,
    output logic               UNLOCKED,
    output logic               ROMCEn,
    output logic               RAMCEn,
    output logic [RADDR_W-1:0] RADDR
);

    typedef enum logic [1:0] {
        ST_WAIT_K0  = 2'd0,
        ST_WAIT_K1  = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  unlocked;
    logic                  stream_load;
    logic [STREAM_LEN-1:0] shreg;
    logic [2:0]            we_sync;
    logic                  we_fall, we_rise;
    logic [7:0]            wr_addr;
    logic [7:0]            wr_data;
    logic                  wr_ok;
    logic                  commit;
    logic [BANK_W-1:0]     bank     [4];
    logic [BANK_W-1:0]     bank_eff [4];
    logic [3:0]            seg;
    logic                  rce, ram_sel, rom_sel;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= ST_WAIT_K0;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_K0:  if (ADDR == KEY0) state_nxt = ST_WAIT_K1;
            ST_WAIT_K1:  if (ADDR == KEY1) state_nxt = ST_UNLOCKED;
            ST_UNLOCKED: state_nxt = ST_UNLOCKED;
            default:     state_nxt = ST_WAIT_K0;
        endcase
    end

    always_comb begin
        unlocked    = (state == ST_UNLOCKED);
        stream_load = (state == ST_WAIT_K1) && (ADDR == KEY1);
    end

    assign UNLOCKED = unlocked;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)            shreg <= '1;
        else if (stream_load) shreg <= STREAM_PAT;
        else                  shreg <= {1'b1, shreg[STREAM_LEN-1:1]};
    end

    assign SO = shreg[0];

    // WEn is asynchronous: two synchroniser flops plus one history flop for edge detection.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) we_sync <= 3'b111;
        else       we_sync <= {we_sync[1:0], WEn};
    end

    assign we_fall = we_sync[2] & ~we_sync[1];
    assign we_rise = ~we_sync[2] & we_sync[1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_ok   <= 1'b0;
        end else if (we_fall) begin
            wr_addr <= ADDR;
            wr_data <= DQ_I;
            wr_ok   <= unlocked & ~(SSn & CEn);
        end else if (we_rise) begin
            wr_ok   <= 1'b0;
        end
    end

    assign commit = we_rise & wr_ok & (wr_addr[7:2] == 6'b110000);

    // NOTE: the four bank registers are reset because their all-ones value is architecturally visible.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 4; i++) bank[i] <= '1;
        end else if (commit) begin
            bank[wr_addr[1:0]] <= BANK_W'(wr_data);
        end
    end

    // Bypass so a committing write is already seen by decode and readback.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bank_eff[i] = bank[i];
            if (commit && (wr_addr[1:0] == 2'(i))) bank_eff[i] = BANK_W'(wr_data);
        end
    end

    assign seg     = ADDR[7:4];
    assign rce     = unlocked & SSn & ~CEn;
    assign ram_sel = rce & (seg == 4'd1);
    assign rom_sel = rce & (seg >= 4'd2);
    assign RAMCEn  = ~ram_sel;
    assign ROMCEn  = ~rom_sel;

    always_comb begin
        RADDR = '0;
        if (ram_sel || rom_sel) begin
            if (seg >= 4'd4) RADDR = {bank_eff[0][RADDR_W-5:0], seg};
            else             RADDR = bank_eff[seg[1:0]][RADDR_W-1:0];
        end
    end

`ifdef BANDAI_READBACK_EN
    assign DQ_OE = unlocked & ~(SSn & CEn) & ~OEn & WEn & (ADDR[7:2] == 6'b110000);
    assign DQ_O  = 8'(bank_eff[ADDR[1:0]]);
`else
    logic unused_rb;
    assign DQ_OE     = 1'b0;
    assign DQ_O      = 8'h00;
    assign unused_rb = ^{OEn, bank_eff[0], bank_eff[1], bank_eff[2], bank_eff[3]};
`endif

endmodule

// File: tb/tb_bandai_mapper_gen2.sv
// Self-checking bench for bandai_mapper_gen2: directed sequences, decode table and randomized traffic.
// Drives a default instance and a RADDR_W=10/BANK_W=10 instance from the same bus.
module tb_bandai_mapper_gen2;

    logic       CLK, RSTn, CEn, SSn, WEn, OEn;
    logic [7:0] ADDR, DQ_I;
    logic [7:0] dq_o, dq_o_w;
    logic       dq_oe, dq_oe_w, so, so_w, unl, unl_w;
    logic       romcen, ramcen, romcen_w, ramcen_w;
    logic [6:0] raddr;
    logic [9:0] raddr_w;

`ifdef BANDAI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    bandai_mapper_gen2 dut (
        .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn),
        .ADDR(ADDR), .DQ_I(DQ_I), .DQ_O(dq_o), .DQ_OE(dq_oe), .SO(so),
        .UNLOCKED(unl), .ROMCEn(romcen), .RAMCEn(ramcen), .RADDR(raddr)
    );

    bandai_mapper_gen2 #(.RADDR_W(10), .BANK_W(10)) dut_w (
        .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn),
        .ADDR(ADDR), .DQ_I(DQ_I), .DQ_O(dq_o_w), .DQ_OE(dq_oe_w), .SO(so_w),
        .UNLOCKED(unl_w), .ROMCEn(romcen_w), .RAMCEn(ramcen_w), .RADDR(raddr_w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: lock flag and register contents for both widths.
    bit         m_unl;
    logic [7:0] mb8  [4];
    logic [9:0] mb10 [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_raddr(input bit wide, input logic [7:0] a, input bit ssn, input bit cen);
        int w;
        int s;
        w = wide ? 10 : 7;
        s = int'(a[7:4]);
        if (!(m_unl && ssn && !cen && s >= 1)) return 0;
        if (s >= 4) return ((int'(wide ? mb10[0] : {2'b00, mb8[0]}) % (1 << (w - 4))) << 4) + s;
        return int'(wide ? mb10[s] : {2'b00, mb8[s]}) % (1 << w);
    endfunction

    function automatic bit exp_oe(input logic [7:0] a, input bit ssn, input bit cen, input bit oen);
        return RB && m_unl && !(ssn && cen) && !oen && (a >= 8'hC0) && (a <= 8'hC3);
    endfunction

    task automatic check_bus(input string tag, input logic [7:0] a, input bit ssn, input bit cen, input bit oen);
        int  s;
        bit  rce;
        bit  oe;
        s   = int'(a[7:4]);
        rce = m_unl && ssn && !cen;
        oe  = exp_oe(a, ssn, cen, oen);
        check({tag, "_romcen"}, 32'(romcen), 32'(!(rce && s >= 2)));
        check({tag, "_ramcen"}, 32'(ramcen), 32'(!(rce && s == 1)));
        check({tag, "_raddr"}, 32'(raddr), 32'(exp_raddr(1'b0, a, ssn, cen)));
        check({tag, "_raddr_w"}, 32'(raddr_w), 32'(exp_raddr(1'b1, a, ssn, cen)));
        check({tag, "_dq_oe"}, 32'(dq_oe), 32'(oe));
        if (!RB)     check({tag, "_dq_o"}, 32'(dq_o), 32'h0);
        else if (oe) check({tag, "_dq_o"}, 32'(dq_o), 32'(mb8[a[1:0]]));
    endtask

    task automatic do_reset();
        RSTn = 1'b0; WEn = 1'b1; OEn = 1'b1; CEn = 1'b1; SSn = 1'b1; ADDR = 8'h00; DQ_I = 8'h00;
        m_unl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mb8[i]  = 8'hFF;
            mb10[i] = 10'h3FF;
        end
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit ssn, input bit cen);
        ADDR = a; DQ_I = d; SSn = ssn; CEn = cen; WEn = 1'b0;
        repeat (4) @(posedge CLK);
        #1 WEn = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        if (m_unl && !(ssn && cen) && a >= 8'hC0 && a <= 8'hC3) begin
            mb8[a[1:0]]  = d;
            mb10[a[1:0]] = {2'b00, d};
        end
    endtask

    task automatic unlock_5a_a5();
        ADDR = 8'h5A;
        @(posedge CLK); #1;
        check("unl_after_k0", 32'(unl), 32'h0);
        ADDR = 8'hA5;
        @(posedge CLK); #1;
        m_unl = 1'b1;
        check("unl_after_k1", 32'(unl), 32'h1);
    endtask

    typedef struct {
        bit         ssn;
        bit         cen;
        bit         oen;
        logic [7:0] addr;
        bit         romcen;
        bit         ramcen;
        logic [6:0] raddr;
        logic [9:0] raddr_w;
        bit         oe;
        logic [7:0] dq;
    } vec_t;

    bit so_exp [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0};

    initial begin
        vec_t tbl [14];
        logic [7:0] a, d;
        bit ssn, cen, oen;

        do_reset();
        // Checked while RSTn is still low, then again after release.
        RSTn = 1'b0; #1;
        check("rst_unlocked", 32'(unl), 32'h0);
        check("rst_so", 32'(so), 32'h1);
        check("rst_romcen", 32'(romcen), 32'h1);
        check("rst_ramcen", 32'(ramcen), 32'h1);
        check("rst_raddr", 32'(raddr), 32'h0);
        check("rst_dq_oe", 32'(dq_oe), 32'h0);
        check("rst_dq_o", 32'(dq_o), 32'h0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Wrong first key: must stay locked, no stream, no chip enables.
        ADDR = 8'hA5;
        repeat (3) @(posedge CLK);
        #1;
        check("k1_first_unl", 32'(unl), 32'h0);
        check("k1_first_so", 32'(so), 32'h1);
        CEn = 1'b0; ADDR = 8'h25; #1;
        check("k1_first_romcen", 32'(romcen), 32'h1);
        CEn = 1'b1;

        // WAIT_K1 holds across a mismatching address.
        ADDR = 8'h5A; @(posedge CLK); #1;
        ADDR = 8'h33; @(posedge CLK); #1;
        ADDR = 8'h33; @(posedge CLK); #1;
        check("hold_k1_unl", 32'(unl), 32'h0);
        ADDR = 8'hA5; @(posedge CLK); #1;
        check("hold_k1_unlocked", 32'(unl), 32'h1);
        check("hold_k1_so0", 32'(so), 32'(so_exp[0]));
        repeat (3) @(posedge CLK);
        #1;
        check("mid_so3", 32'(so), 32'(so_exp[3]));
        #2 RSTn = 1'b0;
        #1;
        check("async_rst_so", 32'(so), 32'h1);
        check("async_rst_unl", 32'(unl), 32'h0);

        // Locked write to RAMB must be dropped.
        do_reset();
        do_write(8'hC1, 8'h00, 1'b0, 1'b1);
        ADDR = 8'h15; SSn = 1'b1; CEn = 1'b0; #1;
        check("locked_ramcen", 32'(ramcen), 32'h1);
        check("locked_raddr", 32'(raddr), 32'h0);
        CEn = 1'b1;
        @(posedge CLK); #1;

        // Unlock and walk the boot stream.
        unlock_5a_a5();
        check("so_bit0", 32'(so), 32'(so_exp[0]));
        for (int i = 1; i < 18; i++) begin
            @(posedge CLK); #1;
            check($sformatf("so_bit%0d", i), 32'(so), 32'(so_exp[i]));
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("so_tail", 32'(so), 32'h1);
        end
        check("so_w_tail", 32'(so_w), 32'h1);
        ADDR = 8'h15; SSn = 1'b1; CEn = 1'b0; #1;
        check("locked_wr_dropped", 32'(raddr), 32'h7F);
        check("locked_wr_dropped_w", 32'(raddr_w), 32'h3FF);

        // Write latency: not visible before WEn rises or one clock after, visible by three.
        @(posedge CLK); #1;
        ADDR = 8'hC2; DQ_I = 8'h15; SSn = 1'b0; CEn = 1'b1; WEn = 1'b0;
        repeat (4) @(posedge CLK);
        #1 ADDR = 8'h25; SSn = 1'b1; CEn = 1'b0; DQ_I = 8'h00;
        @(posedge CLK); #1;
        check("lat_before_rise", 32'(raddr), 32'h7F);
        WEn = 1'b1;
        @(posedge CLK); #1;
        check("lat_1clk", 32'(raddr), 32'h7F);
        repeat (2) @(posedge CLK);
        #1;
        mb8[2] = 8'h15; mb10[2] = 10'h015;
        check("lat_3clk_romcen", 32'(romcen), 32'h0);
        check("lat_3clk_raddr", 32'(raddr), 32'h15);
        check("lat_3clk_raddr_w", 32'(raddr_w), 32'h015);

        // LAO composition and RAMB reset value.
        do_write(8'hC0, 8'h07, 1'b0, 1'b1);
        ADDR = 8'hA0; SSn = 1'b1; CEn = 1'b0; #1;
        check("lao_raddr", 32'(raddr), 32'h7A);
        check("lao_raddr_w", 32'(raddr_w), 32'h07A);
        ADDR = 8'h10; #1;
        check("ramb_ramcen", 32'(ramcen), 32'h0);
        check("ramb_raddr", 32'(raddr), 32'h7F);

        // ROMB1 with wide instance and readback.
        do_write(8'hC3, 8'hAB, 1'b0, 1'b1);
        ADDR = 8'h30; SSn = 1'b1; CEn = 1'b0; #1;
        check("romb1_raddr_w", 32'(raddr_w), 32'h0AB);
        check("romb1_raddr", 32'(raddr), 32'h2B);
        ADDR = 8'hC3; SSn = 1'b0; CEn = 1'b1; OEn = 1'b0; #1;
        check("rb_c3_oe", 32'(dq_oe), 32'(RB));
        check("rb_c3_dq", 32'(dq_o), RB ? 32'hAB : 32'h0);
        OEn = 1'b1;

        // Decode table: LAO=07, RAMB=FF, ROMB0=15, ROMB1=AB.
        tbl[0]  = '{1, 0, 1, 8'h00, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        tbl[1]  = '{1, 0, 1, 8'h15, 1, 0, 7'h7F, 10'h3FF, 0, 8'h00};
        tbl[2]  = '{1, 0, 1, 8'h2F, 0, 1, 7'h15, 10'h015, 0, 8'h00};
        tbl[3]  = '{1, 0, 1, 8'h37, 0, 1, 7'h2B, 10'h0AB, 0, 8'h00};
        tbl[4]  = '{1, 0, 1, 8'h40, 0, 1, 7'h74, 10'h074, 0, 8'h00};
        tbl[5]  = '{1, 0, 1, 8'hF1, 0, 1, 7'h7F, 10'h07F, 0, 8'h00};
        tbl[6]  = '{0, 0, 1, 8'h25, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        tbl[7]  = '{1, 1, 1, 8'h25, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        tbl[8]  = '{0, 1, 1, 8'h80, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        tbl[9]  = '{0, 1, 0, 8'hC2, 1, 1, 7'h00, 10'h000, 1, 8'h15};
        tbl[10] = '{0, 1, 0, 8'hC1, 1, 1, 7'h00, 10'h000, 1, 8'hFF};
        tbl[11] = '{1, 1, 0, 8'hC0, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        tbl[12] = '{0, 1, 0, 8'hC4, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        tbl[13] = '{0, 1, 1, 8'hC3, 1, 1, 7'h00, 10'h000, 0, 8'h00};
        for (int i = 0; i < 14; i++) begin
            SSn = tbl[i].ssn; CEn = tbl[i].cen; OEn = tbl[i].oen; ADDR = tbl[i].addr;
            #1;
            check($sformatf("tbl%0d_romcen", i), 32'(romcen), 32'(tbl[i].romcen));
            check($sformatf("tbl%0d_ramcen", i), 32'(ramcen), 32'(tbl[i].ramcen));
            check($sformatf("tbl%0d_raddr", i), 32'(raddr), 32'(tbl[i].raddr));
            check($sformatf("tbl%0d_raddr_w", i), 32'(raddr_w), 32'(tbl[i].raddr_w));
            check($sformatf("tbl%0d_dq_oe", i), 32'(dq_oe), 32'(RB && tbl[i].oe));
            if (RB && tbl[i].oe) check($sformatf("tbl%0d_dq_o", i), 32'(dq_o), 32'(tbl[i].dq));
            else if (!RB)        check($sformatf("tbl%0d_dq_o", i), 32'(dq_o), 32'h0);
        end
        OEn = 1'b1;

        // Randomized writes and bus accesses against the model.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'hC0 | 8'($urandom_range(0, 3)));
                d   = 8'($urandom);
                ssn = 1'($urandom);
                cen = 1'($urandom);
                OEn = 1'b1;
                do_write(a, d, ssn, cen);
            end
            a   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'hC0 | 8'($urandom_range(0, 3));
            ssn = 1'($urandom);
            cen = 1'($urandom);
            oen = 1'($urandom);
            ADDR = a; SSn = ssn; CEn = cen; OEn = oen;
            #1;
            check_bus($sformatf("rnd%0d", k), a, ssn, cen, oen);
            @(posedge CLK); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
